// File: rtl/bus_pkg.sv
// Shared bus definitions: master indices, default widths, the
// arbitration-pointer type and the two-master priority pick.
package bus_pkg;

    localparam int AW_DEFAULT = 30;
    localparam int DW_DEFAULT = 32;

    localparam int M_CPU    = 0;
    localparam int M_LOADER = 1;

    typedef enum logic {
        PTR_CPU    = 1'b0,
        PTR_LOADER = 1'b1
    } prio_t;

    // A lone requester always wins; on a tie the favoured master wins.
    function automatic logic [1:0] pick_one(input logic [1:0] req, input prio_t ptr);
        logic [1:0] gnt;
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr == PTR_LOADER) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered pointer
// that flips to the other master after every granted transaction.
module rr_arbiter2
    import bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    prio_t ptr;

    // Grant follows the current requests and the favoured master.
    always_comb begin
        gnt = pick_one(req, ptr);
    end

    // After a completed transaction the other master becomes favoured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= PTR_CPU;
        end else if (advance && (gnt != 2'b00)) begin
            ptr <= gnt[M_LOADER] ? PTR_CPU : PTR_LOADER;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter (CPU and loader) in front of one slave port.
// Requests are forwarded combinationally; read results are routed back
// one cycle later to whichever master issued the read.
module mem_arbiter
    import bus_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_re,
    input  logic [DW/8-1:0]   m0_we,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_wdata,
    input  logic              m1_re,
    input  logic [DW/8-1:0]   m1_we,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DW-1:0]     rdata,
    output logic              s_re,
    output logic [DW/8-1:0]   s_we,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_wdata,
    input  logic [DW-1:0]     s_rdata
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       rd_pending;
    prio_t      rd_owner;

    // Requests are masked while reset is held so no grant can leak out.
    always_comb begin
        req           = 2'b00;
        req[M_CPU]    = reset & (m0_re | (|m0_we));
        req[M_LOADER] = reset & (m1_re | (|m1_we));
    end

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (|gnt),
        .gnt     (gnt)
    );

    assign m0_gnt = gnt[M_CPU];
    assign m1_gnt = gnt[M_LOADER];

    // Steer the winner's fields to the slave; strobes stay low when idle.
    always_comb begin
        s_re    = 1'b0;
        s_we    = '0;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        if (gnt[M_LOADER]) begin
            s_re    = m1_re;
            s_we    = m1_we;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
        end else if (gnt[M_CPU]) begin
            s_re    = m0_re;
            s_we    = m0_we;
        end
    end

    // Remember who issued the read so its data comes back to the right master.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= PTR_CPU;
        end else begin
            rd_pending <= s_re;
            if (s_re) begin
                rd_owner <= gnt[M_LOADER] ? PTR_LOADER : PTR_CPU;
            end
        end
    end

    assign m0_rvalid = rd_pending && (rd_owner == PTR_CPU);
    assign m1_rvalid = rd_pending && (rd_owner == PTR_LOADER);
    assign rdata     = s_rdata;

endmodule
